// File: rtl/nibble_pkg.sv
// Shared types for the nibble packer: the nibble type and the packer state encoding.
package nibble_pkg;

  typedef logic [3:0] nibble_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_FULL
  } pack_state_t;

endpackage : nibble_pkg

// File: rtl/nibble_packer.sv
// Gathers a stream of 4-bit nibbles into NIBBLES-wide words, least-significant
// nibble first. A nibble flagged in_last closes a partially filled word early.
// Both sides use valid/ready handshakes.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  nibble_t                        in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [4*NIBBLES-1:0]           out_data,
  output logic [$clog2(NIBBLES+1)-1:0]   out_count,
  output logic                           out_last
);

  localparam int IW = $clog2(NIBBLES);
  localparam int CW = $clog2(NIBBLES + 1);

  typedef logic [4*NIBBLES-1:0] word_t;

  pack_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  word_t           asm_q, asm_d;
  logic            out_valid_q, out_valid_d;
  word_t           out_data_q, out_data_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic            out_last_q, out_last_d;

  logic            accept;
  logic            transfer;
  logic            word_done;
  word_t           asm_with_nib;

  // A held word blocks input unless the consumer drains it in the same cycle.
  assign in_ready  = (state_q != S_FULL) || out_ready;

  assign accept    = in_valid && in_ready;
  assign transfer  = out_valid_q && out_ready;
  assign word_done = (idx_q == IW'(NIBBLES - 1)) || in_last;

  // Unfilled slots of the assembly register are always zero, so OR-ing the
  // shifted nibble in is enough to place it.
  assign asm_with_nib = asm_q | (word_t'(in_data) << (4 * idx_q));

  // Next-state logic: transfer retires the held word, then an accept either
  // extends the word being built or completes it into the output register.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;

    if (transfer) begin
      out_valid_d = 1'b0;
      state_d     = S_IDLE;
    end

    if (accept) begin
      if (word_done) begin
        out_data_d  = asm_with_nib;
        out_count_d = CW'(idx_q) + CW'(1);
        out_last_d  = in_last;
        out_valid_d = 1'b1;
        idx_d       = '0;
        asm_d       = '0;
        state_d     = S_FULL;
      end else begin
        idx_d       = idx_q + IW'(1);
        asm_d       = asm_with_nib;
        state_d     = S_FILL;
      end
    end
  end

  // State and datapath registers; reset discards any partial or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

endmodule : nibble_packer

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer with NIBBLES=2 and NIBBLES=4 instances.
// A queue-based model of completed-but-not-taken words predicts every output.
module tb_nibble_packer;

  logic clk = 1'b0;
  logic rst;

  logic       in_valid2, in_last2, out_ready2, in_ready2, out_valid2, out_last2;
  logic [3:0] in_data2;
  logic [7:0] out_data2;
  logic [1:0] out_count2;

  logic        in_valid4, in_last4, out_ready4, in_ready4, out_valid4, out_last4;
  logic [3:0]  in_data4;
  logic [15:0] out_data4;
  logic [2:0]  out_count4;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  c;
    logic        l;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] m_word[2];
  int          m_cnt[2];

  always #5 clk = ~clk;

  nibble_packer #(.NIBBLES(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_count(out_count2), .out_last(out_last2)
  );

  nibble_packer #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_last(in_last4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_count(out_count4), .out_last(out_last4)
  );

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int k, input exp_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_word[i] = '0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic idle_inputs();
    in_valid2 = 1'b0; in_data2 = 4'h0; in_last2 = 1'b0; out_ready2 = 1'b0;
    in_valid4 = 1'b0; in_data4 = 4'h0; in_last4 = 1'b0; out_ready4 = 1'b0;
  endtask

  // One clock of stimulus on instance k (0: NIBBLES=2, 1: NIBBLES=4).
  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input int k, input logic v, input logic [3:0] d,
                      input logic l, input logic r);
    logic        rdy, ov, ol, rdy_exp;
    logic [31:0] od;
    logic [3:0]  oc;
    exp_t        e;
    int          n;
    if (k == 0) begin
      in_valid2 = v; in_data2 = d; in_last2 = l; out_ready2 = r;
      in_valid4 = 1'b0; out_ready4 = 1'b0;
    end else begin
      in_valid4 = v; in_data4 = d; in_last4 = l; out_ready4 = r;
      in_valid2 = 1'b0; out_ready2 = 1'b0;
    end
    #1;
    if (k == 0) begin
      rdy = in_ready2; ov = out_valid2; od = {24'b0, out_data2};
      oc = {2'b0, out_count2}; ol = out_last2; n = 2;
    end else begin
      rdy = in_ready4; ov = out_valid4; od = {16'b0, out_data4};
      oc = {1'b0, out_count4}; ol = out_last4; n = 4;
    end

    // The packer holds at most one word; input is blocked only while it is
    // held and the consumer is not taking it.
    rdy_exp = (qsize(k) == 0) || r;
    total++;
    if (rdy !== rdy_exp) begin
      bad++;
      $display("FAIL in_ready k=%0d got=%b want=%b", k, rdy, rdy_exp);
    end
    total++;
    if (ov !== (qsize(k) != 0)) begin
      bad++;
      $display("FAIL out_valid k=%0d got=%b want=%b", k, ov, (qsize(k) != 0));
    end

    if (qsize(k) != 0) begin
      e = qfront(k);
      if (ov === 1'b1) begin
        total++;
        if (od !== e.d) begin
          bad++;
          $display("FAIL out_data k=%0d got=%h want=%h", k, od, e.d);
        end
        total++;
        if (oc !== e.c) begin
          bad++;
          $display("FAIL out_count k=%0d got=%0d want=%0d", k, oc, e.c);
        end
        total++;
        if (ol !== e.l) begin
          bad++;
          $display("FAIL out_last k=%0d got=%b want=%b", k, ol, e.l);
        end
      end
      if (r) begin
        $display("word k=%0d data=%h count=%0d last=%0b", k, od, oc, ol);
        qpop(k);
      end
    end

    if (v && rdy_exp) begin
      m_word[k] = m_word[k] | (32'(d) << (4 * m_cnt[k]));
      m_cnt[k]++;
      if (m_cnt[k] == n || l) begin
        e.d = m_word[k];
        e.c = 4'(m_cnt[k]);
        e.l = l;
        qpush(k, e);
        m_word[k] = '0;
        m_cnt[k]  = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if (out_valid2 !== 1'b0 || out_data2 !== 8'h00 || out_count2 !== 2'd0 || out_last2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_n2 got v=%b d=%h c=%0d l=%b want all zero",
               out_valid2, out_data2, out_count2, out_last2);
    end
    total++;
    if (out_valid4 !== 1'b0 || out_data4 !== 16'h0000 || out_count4 !== 3'd0 || out_last4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_n4 got v=%b d=%h c=%0d l=%b want all zero",
               out_valid4, out_data4, out_count4, out_last4);
    end
    total++;
    if (in_ready2 !== 1'b1 || in_ready4 !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready got=%b%b want=11", in_ready2, in_ready4);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    step(0, 1'b1, 4'h5, 1'b0, 1'b1);
    step(0, 1'b1, 4'hA, 1'b0, 1'b1);
    #1;
    total++;
    if (out_valid2 !== 1'b1 || out_data2 !== 8'hA5 || out_count2 !== 2'd2 || out_last2 !== 1'b0) begin
      bad++;
      $display("FAIL basic_word got v=%b d=%h c=%0d l=%b want 1 a5 2 0",
               out_valid2, out_data2, out_count2, out_last2);
    end
    step(0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    do_reset();
    step(0, 1'b1, 4'h5, 1'b1, 1'b1);
    #1;
    total++;
    if (out_data2 !== 8'h05 || out_count2 !== 2'd1 || out_last2 !== 1'b1) begin
      bad++;
      $display("FAIL flush_word got d=%h c=%0d l=%b want 05 1 1", out_data2, out_count2, out_last2);
    end
    // Drain cycle: the next nibble starts a fresh word at bits [3:0].
    step(0, 1'b1, 4'h3, 1'b0, 1'b1);
    step(0, 1'b1, 4'hA, 1'b0, 1'b1);
    #1;
    total++;
    if (out_data2 !== 8'hA3) begin
      bad++;
      $display("FAIL flush_next got=%h want=a3", out_data2);
    end
    // Drain cycle with in_last: a 1-nibble word replaces the leaving one.
    step(0, 1'b1, 4'h6, 1'b1, 1'b1);
    step(0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_stall();
    do_reset();
    step(0, 1'b1, 4'h5, 1'b0, 1'b0);
    step(0, 1'b1, 4'hA, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 4'h3, 1'b0, 1'b0);
    #1;
    total++;
    if (out_data2 !== 8'hA5 || in_ready2 !== 1'b0) begin
      bad++;
      $display("FAIL stall_hold got d=%h rdy=%b want a5 0", out_data2, in_ready2);
    end
    step(0, 1'b1, 4'h3, 1'b0, 1'b1);
    step(0, 1'b1, 4'hC, 1'b0, 1'b1);
    #1;
    total++;
    if (out_data2 !== 8'hC3) begin
      bad++;
      $display("FAIL stall_drain got=%h want=c3", out_data2);
    end
    step(0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] nibs [4];
    nibs[0] = 4'h5; nibs[1] = 4'hA; nibs[2] = 4'h2; nibs[3] = 4'h4;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1'b1, nibs[i], 1'b0, 1'b1);
    #1;
    total++;
    if (out_data2 !== 8'h42 || out_valid2 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got d=%h v=%b want 42 1", out_data2, out_valid2);
    end
    step(0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 1'b1, 4'h5, 1'b0, 1'b1);
    // Reset must win over an accept of a completing nibble.
    rst = 1'b1;
    in_valid2 = 1'b1; in_data2 = 4'h9; in_last2 = 1'b1; out_ready2 = 1'b1;
    #1;
    total++;
    if (out_valid2 !== 1'b0) begin
      bad++;
      $display("FAIL rst_during got v=%b want 0", out_valid2);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    clear_model();
    #1;
    total++;
    if (out_valid2 !== 1'b0) begin
      bad++;
      $display("FAIL rst_after got v=%b want 0", out_valid2);
    end
    step(0, 1'b1, 4'h7, 1'b0, 1'b1);
    step(0, 1'b1, 4'h1, 1'b0, 1'b1);
    #1;
    total++;
    if (out_data2 !== 8'h17 || out_count2 !== 2'd2) begin
      bad++;
      $display("FAIL rst_word got d=%h c=%0d want 17 2", out_data2, out_count2);
    end
    step(0, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_n4();
    do_reset();
    step(1, 1'b1, 4'h5, 1'b0, 1'b1);
    step(1, 1'b1, 4'hA, 1'b0, 1'b1);
    step(1, 1'b1, 4'h2, 1'b0, 1'b1);
    step(1, 1'b1, 4'h4, 1'b0, 1'b1);
    #1;
    total++;
    if (out_data4 !== 16'h42A5 || out_count4 !== 3'd4 || out_last4 !== 1'b0) begin
      bad++;
      $display("FAIL n4_word got d=%h c=%0d l=%b want 42a5 4 0", out_data4, out_count4, out_last4);
    end
    step(1, 1'b1, 4'h9, 1'b1, 1'b1);
    #1;
    total++;
    if (out_data4 !== 16'h0009 || out_count4 !== 3'd1 || out_last4 !== 1'b1) begin
      bad++;
      $display("FAIL n4_flush got d=%h c=%0d l=%b want 0009 1 1", out_data4, out_count4, out_last4);
    end
    step(1, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random(input int k);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(k, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) step(k, 1'b0, 4'h0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    clear_model();
    @(negedge clk);
    test_reset();
    test_basic();
    test_flush();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_n4();
    test_random(0);
    test_random(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nibble_packer
